// File: rtl/serial_adder_pkg.sv
// Shared constants and FSM state type for the bit-serial adder.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package serial_adder_pkg;

  // Default operand/sum width in bits.
  localparam int SA_WIDTH = 8;

  // Control FSM states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } sa_state_t;

endpackage

// File: rtl/serial_adder_full_adder.sv
// One-bit full adder used as the serial adder's per-bit datapath.
// Latency: purely combinational, zero cycles.
// Backpressure: none; outputs follow inputs.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ c;
  assign cout = (a & b) | (b & c) | (c & a);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: adds a + b + cin one bit per clock, LSB first.
// Latency: done pulses WIDTH+1 clocks after the edge that samples start (busy for WIDTH cycles).
// Backpressure: start is only sampled in IDLE; requests during SHIFT/DONE are dropped.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = SA_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int              CW       = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0]   LAST_BIT = CW'(WIDTH - 1);
  localparam logic [CW-1:0]   CNT_ONE  = CW'(1);

  sa_state_t        state;
  sa_state_t        state_nxt;

  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic             carry;
  logic [CW-1:0]    cnt;

  // Holds the WIDTH-1 sum bits already produced; the final bit comes
  // straight from the adder on the last SHIFT edge, so the full result
  // is {fa_sum, res_sh} at that moment.
  logic [WIDTH-2:0] res_sh;
  logic [WIDTH-1:0] res_cat;

  logic             fa_sum;
  logic             fa_cout;
  logic             capture;
  logic             last_bit;

  full_adder u_fa (
    .a    (a_sh[0]),
    .b    (b_sh[0]),
    .c    (carry),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  assign res_cat = {fa_sum, res_sh};

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode plus busy/done and datapath strobes.
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    capture   = 1'b0;
    last_bit  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          capture   = 1'b1;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        busy = 1'b1;
        if (cnt == LAST_BIT) begin
          last_bit  = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Operand capture, then one right shift per SHIFT cycle with carry update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh   <= '0;
      b_sh   <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      res_sh <= '0;
    end else if (capture) begin
      a_sh   <= a;
      b_sh   <= b;
      carry  <= cin;
      cnt    <= '0;
      res_sh <= '0;
    end else if (busy) begin
      a_sh   <= a_sh >> 1;
      b_sh   <= b_sh >> 1;
      carry  <= fa_cout;
      res_sh <= res_cat[WIDTH-1:1];
      cnt    <= cnt + CNT_ONE;
    end
  end

  // Result registers update only on the final bit, so they hold the
  // previous answer throughout a new operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum  <= '0;
      cout <= 1'b0;
    end else if (last_bit) begin
      sum  <= res_cat;
      cout <= fa_cout;
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder against an arithmetic reference model.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_serial_adder;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;

  int n_cmp = 0;
  int n_mis = 0;

  // Result the DUT should currently be holding on sum/cout.
  logic [W-1:0] held_sum  = '0;
  logic         held_cout = 1'b0;

  serial_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference: plain (W+1)-bit addition.
  function automatic logic [W:0] ref_add(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
    return {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
  endfunction

  task automatic scramble_inputs();
    a   = W'($urandom);
    b   = W'($urandom);
    cin = 1'($urandom);
  endtask

  // One operation with a start pulse; optionally fires extra start pulses
  // (with junk operands) while busy, which must be ignored.
  task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic cv,
                        input bit poke, input string name);
    logic [W:0] r;
    int edges;
    int busy_n;
    bit got;
    r = ref_add(av, bv, cv);
    @(negedge clk);
    a = av; b = bv; cin = cv; start = 1'b1;
    @(posedge clk);
    edges = 1;
    busy_n = 0;
    got = 1'b0;
    @(negedge clk);
    start = 1'b0;
    scramble_inputs();
    for (int i = 0; i < 4 * W; i++) begin
      if (done) begin
        got = 1'b1;
        break;
      end
      if (busy) busy_n++;
      check({name, "_held_sum"}, sum, held_sum);
      check({name, "_held_cout"}, cout, held_cout);
      start = (poke && (i % 3 == 1)) ? 1'b1 : 1'b0;
      scramble_inputs();
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
    start = 1'b0;
    check({name, "_done_seen"}, got, 1);
    check({name, "_latency"}, edges, W + 1);
    check({name, "_busy_cycles"}, busy_n, W);
    check({name, "_sum"}, sum, r[W-1:0]);
    check({name, "_cout"}, cout, r[W]);
    held_sum  = r[W-1:0];
    held_cout = r[W];
    @(negedge clk);
    check({name, "_done_1cyc"}, done, 0);
    check({name, "_idle_busy"}, busy, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W:0]   r;
    logic [W-1:0] av;
    logic [W-1:0] bv;
    logic         cv;
    int           dn;
    int           bz;

    rst_n = 1'b0;
    start = 1'b0;
    a = '0; b = '0; cin = 1'b0;
    #3;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_sum", sum, 0);
    check("rst_cout", cout, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    run_op(8'h00, 8'h00, 1'b0, 1'b0, "zero");
    run_op(8'hFF, 8'h01, 1'b0, 1'b0, "ovf");
    run_op(8'h77, 8'h11, 1'b0, 1'b0, "prior");
    run_op(8'hA5, 8'h5A, 1'b1, 1'b1, "a5_5a_poke");
    run_op(8'h3C, 8'h0F, 1'b1, 1'b0, "pre_rst");
    for (int k = 0; k < 6; k++) begin
      run_op(W'($urandom), W'($urandom), 1'($urandom), bit'(k % 2), "rand");
    end

    // Abort in the 4th SHIFT cycle.
    @(negedge clk);
    a = 8'h12; b = 8'h34; cin = 1'b0; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("abort_busy_before", busy, 1);
    check("abort_sum_before", sum, held_sum);
    rst_n = 1'b0;
    #1;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_sum", sum, 0);
    check("abort_cout", cout, 0);
    held_sum = '0;
    held_cout = 1'b0;
    dn = 0;
    repeat (3) begin
      @(negedge clk);
      if (done) dn++;
    end
    rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (done) dn++;
      check("abort_idle_busy", busy, 0);
    end
    check("abort_no_done", dn, 0);
    run_op(8'h12, 8'h34, 1'b0, 1'b0, "after_abort");

    // Back-to-back with start held high; one op every W+2 cycles.
    @(negedge clk);
    start = 1'b1;
    for (int op = 0; op < 1000; op++) begin
      check("b2b_idle", {30'b0, busy, done}, 0);
      av = W'($urandom);
      bv = W'($urandom);
      cv = 1'($urandom);
      a = av; b = bv; cin = cv;
      r = ref_add(av, bv, cv);
      @(posedge clk);
      dn = 0;
      bz = 0;
      for (int k = 1; k <= W + 1; k++) begin
        @(negedge clk);
        if (done) dn++;
        if (busy) bz++;
        if (k == W + 1) begin
          check("b2b_done_at_end", done, 1);
          check("b2b_sum", sum, r[W-1:0]);
          check("b2b_cout", cout, r[W]);
        end
        scramble_inputs();
        @(posedge clk);
      end
      check("b2b_one_done", dn, 1);
      check("b2b_busy_cycles", bz, W);
      @(negedge clk);
    end
    start = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
